// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives a synchronous ROM and presents
// {pc_4, instruction, valid} to IF/ID. Optional syscall halt under `FETCH_HALT_EN.
module if_fetch #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        redirect,
  input  logic [11:0] redirect_pc,
  output logic        imem_en,
  output logic [11:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [11:0] pc_4,
  output logic [31:0] instruction,
  output logic        valid,
  output logic        halted
);

  // Handshake: the presented word is consumed on a rising edge where valid=1 and go=1;
  // while valid=1 and go=0 every output and imem_rdata are held.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1
`ifdef FETCH_HALT_EN
    , HALT = 2'd2
`endif
  } st_t;

  st_t         st, st_n;
  logic [11:0] fpc, fpc_n;
  logic [11:0] rpc, rpc_n;
  logic        rvalid, rvalid_n;
  logic        en_c;
  logic [11:0] addr_c;
  logic [11:0] next_pc;
  logic [11:0] target;
  logic        fire;

  assign next_pc     = fpc + 12'd4;
  assign target      = {redirect_pc[11:2], 2'b00};
  assign fire        = rvalid & go;
  assign pc_4        = rpc + 12'd4;
  assign instruction = rvalid ? imem_rdata : 32'h0;
  assign valid       = rvalid;

  // Gating keeps the memory quiet and the address defined while reset is asserted.
  assign imem_en   = en_c & rst_n;
  assign imem_addr = rst_n ? addr_c : fpc;

`ifdef FETCH_HALT_EN
  assign halted = (st == HALT);
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    st_n     = st;
    fpc_n    = fpc;
    rpc_n    = rpc;
    rvalid_n = rvalid;
    en_c     = 1'b0;
    addr_c   = fpc;
    if (redirect) begin
      en_c     = 1'b1;
      addr_c   = target;
      rpc_n    = target;
      fpc_n    = target + 12'd4;
      rvalid_n = 1'b1;
      st_n     = RUN;
    end else begin
      case (st)
        BOOT: begin
          en_c     = 1'b1;
          rpc_n    = fpc;
          fpc_n    = next_pc;
          rvalid_n = 1'b1;
          st_n     = RUN;
        end
        RUN: begin
`ifdef FETCH_HALT_EN
          if (fire && (instruction == 32'h0000_000C)) begin
            rvalid_n = 1'b0;
            st_n     = HALT;
          end else
`endif
          if (fire || !rvalid) begin
            en_c     = 1'b1;
            rpc_n    = fpc;
            fpc_n    = next_pc;
            rvalid_n = 1'b1;
          end
        end
`ifdef FETCH_HALT_EN
        HALT: begin
          rvalid_n = 1'b0;
        end
`endif
        default: begin
          st_n     = BOOT;
          rvalid_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= BOOT;
      fpc    <= RESET_PC;
      rpc    <= 12'h000;
      rvalid <= 1'b0;
    end else begin
      st     <= st_n;
      fpc    <= fpc_n;
      rpc    <= rpc_n;
      rvalid <= rvalid_n;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: vector table for fetch/stall/redirect/wrap, plus hand
// sequences for async reset and (when FETCH_HALT_EN is defined) syscall halt.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = 12'h000;
  logic        imem_en;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [11:0] pc_4;
  logic [31:0] instruction;
  logic        valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [0:1023];

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_4(pc_4), .instruction(instruction), .valid(valid), .halted(halted)
  );

  // Synchronous ROM model: samples address on posedge when enabled, otherwise holds.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom[imem_addr[11:2]];
  end

  typedef struct {
    logic        go;
    logic        redir;
    logic [11:0] rpc;
    logic        val;
    logic [11:0] pc4;
    logic [31:0] ins;
    logic        en;
    logic [11:0] addr;
  } vec_t;

  vec_t vec [0:14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [11:0] p,
                         input logic [31:0] i, input logic e, input logic [11:0] a,
                         input logic h);
    chk({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
    chk({tag, ".pc_4"}, {20'b0, pc_4}, {20'b0, p});
    chk({tag, ".instruction"}, instruction, i);
    chk({tag, ".imem_en"}, {31'b0, imem_en}, {31'b0, e});
    chk({tag, ".imem_addr"}, {20'b0, imem_addr}, {20'b0, a});
    chk({tag, ".halted"}, {31'b0, halted}, {31'b0, h});
  endtask

  // Inputs change 1 ns after posedge; outputs are checked 1 ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h1000_0000 + i;

    //            go    redir  rpc      val   pc4      ins            en    addr
    vec[0]  = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h004, 32'h0000_0000, 1'b1, 12'h000};
    vec[1]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h004, 32'h1000_0000, 1'b1, 12'h004};
    vec[2]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h008, 32'h1000_0001, 1'b1, 12'h008};
    vec[3]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h00C, 32'h1000_0002, 1'b0, 12'h00C};
    vec[4]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h00C, 32'h1000_0002, 1'b0, 12'h00C};
    vec[5]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h00C, 32'h1000_0002, 1'b0, 12'h00C};
    vec[6]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h00C, 32'h1000_0002, 1'b1, 12'h00C};
    vec[7]  = '{1'b0, 1'b1, 12'h103, 1'b1, 12'h010, 32'h1000_0003, 1'b1, 12'h100};
    vec[8]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h104, 32'h1000_0040, 1'b1, 12'h104};
    vec[9]  = '{1'b1, 1'b1, 12'hFFC, 1'b1, 12'h108, 32'h1000_0041, 1'b1, 12'hFFC};
    vec[10] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 32'h1000_03FF, 1'b1, 12'h000};
    vec[11] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h004, 32'h1000_0000, 1'b1, 12'h004};
    vec[12] = '{1'b0, 1'b1, 12'h022, 1'b1, 12'h008, 32'h1000_0001, 1'b1, 12'h020};
    vec[13] = '{1'b0, 1'b1, 12'h020, 1'b1, 12'h024, 32'h1000_0008, 1'b1, 12'h020};
    vec[14] = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h024, 32'h1000_0008, 1'b0, 12'h024};

    // Reset state, with redirect asserted to confirm it cannot leak through.
    go = 1'b1;
    redirect = 1'b1;
    redirect_pc = 12'h200;
    #2;
    chk_out("reset", 1'b0, 12'h004, 32'h0, 1'b0, 12'h000, 1'b0);
    redirect = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int k = 0; k < 15; k++) begin
      go = vec[k].go;
      redirect = vec[k].redir;
      redirect_pc = vec[k].rpc;
      #1;
      chk_out($sformatf("vec%0d", k), vec[k].val, vec[k].pc4, vec[k].ins,
              vec[k].en, vec[k].addr, 1'b0);
      next_cycle();
    end

    // Async reset in the middle of a stall cycle, no clock edge in between.
    go = 1'b0;
    redirect = 1'b0;
    #1;
    chk_out("stall_hold", 1'b1, 12'h024, 32'h1000_0008, 1'b0, 12'h024, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 12'h004, 32'h0, 1'b0, 12'h000, 1'b0);

    // Refetch from RESET_PC; ROM[3] becomes a syscall for the halt sequence.
    rom[3] = 32'h0000_000C;
    go = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("boot0", 1'b0, 12'h004, 32'h0, 1'b1, 12'h000, 1'b0);
    next_cycle();
    #1;
    chk_out("boot1", 1'b1, 12'h004, 32'h1000_0000, 1'b1, 12'h004, 1'b0);
    next_cycle();
    #1;
    chk_out("boot2", 1'b1, 12'h008, 32'h1000_0001, 1'b1, 12'h008, 1'b0);
    next_cycle();
    #1;
    chk_out("boot3", 1'b1, 12'h00C, 32'h1000_0002, 1'b1, 12'h00C, 1'b0);
    next_cycle();
    #1;
`ifdef FETCH_HALT_EN
    chk_out("syscall", 1'b1, 12'h010, 32'h0000_000C, 1'b0, 12'h010, 1'b0);
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      #1;
      chk_out($sformatf("halt%0d", c), 1'b0, 12'h010, 32'h0, 1'b0, 12'h010, 1'b1);
    end
    redirect = 1'b1;
    redirect_pc = 12'h040;
    #1;
    chk_out("halt_redir", 1'b0, 12'h010, 32'h0, 1'b1, 12'h040, 1'b1);
    next_cycle();
    redirect = 1'b0;
    #1;
    chk_out("halt_exit", 1'b1, 12'h044, 32'h1000_0010, 1'b1, 12'h044, 1'b0);
`else
    chk_out("syscall", 1'b1, 12'h010, 32'h0000_000C, 1'b1, 12'h010, 1'b0);
    next_cycle();
    #1;
    chk_out("post_sys", 1'b1, 12'h014, 32'h1000_0004, 1'b1, 12'h014, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
